// File: rtl/multi_slave_bridge_if.sv
// CPU-side and slave-side bus of the multi-slave bridge.
// Modports: master = bridge, slave = peripherals, cpu = CPU.
interface multi_slave_bridge_if #(
  parameter int N_SLV  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                      cpu_req;
  logic                      cpu_wen;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_done;
  logic                      cpu_stall;
  logic                      cpu_err;
  logic [N_SLV-1:0]          slv_sel;
  logic                      slv_wen;
  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [N_SLV*DATA_W-1:0]   slv_rdata;
  logic [N_SLV-1:0]          slv_ack;

  modport master (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall, cpu_err,
    output slv_sel, slv_wen, slv_addr, slv_wdata,
    input  slv_rdata, slv_ack
  );

  modport slave (
    input  slv_sel, slv_wen, slv_addr, slv_wdata,
    output slv_rdata, slv_ack
  );

  modport cpu (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall, cpu_err
  );
endinterface

// File: rtl/multi_slave_bridge.sv
// CPU-to-peripheral bridge: window decode, req/ack handshake with timeout, unmapped-address error.
// Optional BRIDGE_ERR_LOG_EN adds err_addr/err_cnt/err_clr error logging.
module multi_slave_bridge #(
  parameter int                      N_SLV   = 4,
  parameter int                      ADDR_W  = 32,
  parameter int                      DATA_W  = 32,
  parameter int                      TIMEOUT = 15,
  parameter logic [N_SLV*ADDR_W-1:0] BASE    = '0,
  parameter logic [N_SLV*ADDR_W-1:0] MASK    = '0
) (
  input  logic                 clk_from_cpu,
  input  logic                 rst_from_cpu,
`ifdef BRIDGE_ERR_LOG_EN
  output logic [ADDR_W-1:0]    err_addr,
  output logic [7:0]           err_cnt,
  input  logic                 err_clr,
`endif
  multi_slave_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [N_SLV-1:0]  hit_oh;
  logic              any_hit;
  logic              ack_sel;
  logic [DATA_W-1:0] rdata_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lowest-index window wins when windows overlap.
  always_comb begin
    hit_oh  = '0;
    any_hit = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!any_hit &&
          ((bus.cpu_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
        hit_oh[i] = 1'b1;
        any_hit   = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (bus.slv_sel[i]) rdata_sel = bus.slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign ack_sel       = |(bus.slv_ack & bus.slv_sel);
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;

  always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
    if (rst_from_cpu) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.slv_sel   <= '0;
      bus.slv_wen   <= 1'b0;
      bus.slv_addr  <= '0;
      bus.slv_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_err   <= 1'b0;
    end else begin
      bus.cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            bus.slv_addr  <= bus.cpu_addr;
            bus.slv_wdata <= bus.cpu_wdata;
            bus.slv_wen   <= bus.cpu_wen & any_hit;
            cnt           <= '0;
            if (any_hit) begin
              bus.slv_sel <= hit_oh;
              state       <= REQ;
            end else begin
              bus.cpu_rdata <= '0;
              bus.cpu_err   <= 1'b1;
              bus.cpu_done  <= 1'b1;
              state         <= RESP;
            end
          end
        end
        REQ: begin
          // An ack arriving on the last allowed cycle still completes without error.
          if (ack_sel) begin
            bus.cpu_rdata <= bus.slv_wen ? '0 : rdata_sel;
            bus.cpu_err   <= 1'b0;
            bus.cpu_done  <= 1'b1;
            bus.slv_sel   <= '0;
            bus.slv_wen   <= 1'b0;
            cnt           <= '0;
            state         <= RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            bus.cpu_rdata <= '1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_done  <= 1'b1;
            bus.slv_sel   <= '0;
            bus.slv_wen   <= 1'b0;
            cnt           <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          bus.slv_sel <= '0;
          cnt         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRIDGE_ERR_LOG_EN
  // Logged during the done cycle; slv_addr still holds the failing address then.
  always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
    if (rst_from_cpu) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (bus.cpu_done && bus.cpu_err) begin
      err_addr <= bus.slv_addr;
      err_cnt  <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_multi_slave_bridge.sv
// Directed bench for multi_slave_bridge: decode, wait states, unmapped, timeout, reset, error log.
module tb_multi_slave_bridge;
  localparam int N_SLV   = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam logic [N_SLV*ADDR_W-1:0] BASE =
    {32'h0000_0000, 32'h2000_0000, 32'hFFFF_F000, 32'h0000_0000};
  localparam logic [N_SLV*ADDR_W-1:0] MASK =
    {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_slave_bridge_if #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef BRIDGE_ERR_LOG_EN
  logic [ADDR_W-1:0] err_addr;
  logic [7:0]        err_cnt;
  logic              err_clr;
`endif

  multi_slave_bridge #(
    .N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT),
    .BASE(BASE), .MASK(MASK)
  ) dut (
    .clk_from_cpu (clk),
    .rst_from_cpu (rst),
`ifdef BRIDGE_ERR_LOG_EN
    .err_addr     (err_addr),
    .err_cnt      (err_cnt),
    .err_clr      (err_clr),
`endif
    .bus          (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave model: selected slave acks ack_wait[i] cycles after select (-1 = never).
  int         ack_wait [N_SLV];
  logic [3:0] noise_ack;
  int         wcnt;
  always @(negedge clk) begin
    logic [3:0] a;
    a = '0;
    if (bus.slv_sel != '0) begin
      for (int i = 0; i < N_SLV; i++)
        if (bus.slv_sel[i] && ack_wait[i] >= 0 && wcnt == ack_wait[i]) a[i] = 1'b1;
      wcnt++;
    end else begin
      wcnt = 0;
    end
    bus.slv_ack = a | noise_ack;
  end

  int          lat;
  logic [31:0] rd, wdata2, addr2;
  logic        er, stall1, wen2, clr_on_done;
  logic [3:0]  sel1, sel_or;

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_wen = w; bus.cpu_addr = a; bus.cpu_wdata = d;
    lat = -1; sel_or = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      sel_or |= bus.slv_sel;
      if (k == 1) begin
        sel1 = bus.slv_sel; stall1 = bus.cpu_stall;
        bus.cpu_addr = ~a; bus.cpu_wdata = ~d; bus.cpu_wen = ~w;
      end
      if (k == 2) begin
        wen2 = bus.slv_wen; wdata2 = bus.slv_wdata; addr2 = bus.slv_addr;
      end
      if (bus.cpu_done) begin
        lat = k; rd = bus.cpu_rdata; er = bus.cpu_err;
`ifdef BRIDGE_ERR_LOG_EN
        if (clr_on_done) err_clr = 1'b1;
`endif
      end
    end
    bus.cpu_req = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    if (lat < 0) begin
      chk("done_seen", 64'(bus.cpu_done), 64'd1);
    end else begin
      @(posedge clk); #1;
`ifdef BRIDGE_ERR_LOG_EN
      err_clr = 1'b0;
`endif
      chk("done_1cyc", 64'(bus.cpu_done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_wen = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hCAFE_0000};
    bus.slv_ack = '0;
    ack_wait = '{0, 3, -1, 0};
    noise_ack = '0; clr_on_done = 1'b0;
`ifdef BRIDGE_ERR_LOG_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",   64'(bus.slv_sel),   64'd0);
    chk("rst_done",  64'(bus.cpu_done),  64'd0);
    chk("rst_err",   64'(bus.cpu_err),   64'd0);
    chk("rst_rdata", 64'(bus.cpu_rdata), 64'd0);
    chk("rst_addr",  64'(bus.slv_addr),  64'd0);
    chk("rst_stall", 64'(bus.cpu_stall), 64'd0);
    rst = 1'b0;

    // Zero-wait read; 0000_0010 also hits slot 3, slot 0 must win.
    access(1'b0, 32'h0000_0010, 32'h0);
    chk("t1_lat",   64'(lat),    64'd2);
    chk("t1_sel",   64'(sel1),   64'h1);
    chk("t1_stall", 64'(stall1), 64'd1);
    chk("t1_rdata", 64'(rd),     64'hCAFE_0000);
    chk("t1_err",   64'(er),     64'd0);

    // Write to slave 1 with 3 wait states; inputs scrambled after latch.
    access(1'b1, 32'hFFFF_F060, 32'h1234_5678);
    chk("t2_lat",   64'(lat),    64'd5);
    chk("t2_sel",   64'(sel1),   64'h2);
    chk("t2_wen",   64'(wen2),   64'd1);
    chk("t2_wdata", 64'(wdata2), 64'h1234_5678);
    chk("t2_addr",  64'(addr2),  64'hFFFF_F060);
    chk("t2_rdata", 64'(rd),     64'd0);
    chk("t2_err",   64'(er),     64'd0);

    // Unmapped.
    access(1'b0, 32'h8000_0000, 32'h0);
    chk("t3_lat",   64'(lat),    64'd1);
    chk("t3_err",   64'(er),     64'd1);
    chk("t3_rdata", 64'(rd),     64'd0);
    chk("t3_sel",   64'(sel_or), 64'd0);

    // Timeout with stray acks on unselected channels.
    noise_ack = 4'b1001;
    access(1'b0, 32'h2000_0004, 32'h0);
    noise_ack = '0;
    chk("t4_lat",   64'(lat),  64'd16);
    chk("t4_sel",   64'(sel1), 64'h4);
    chk("t4_err",   64'(er),   64'd1);
    chk("t4_rdata", 64'(rd),   64'hFFFF_FFFF);

    // Ack on the exact timeout cycle, then one cycle before it.
    ack_wait[2] = 14;
    access(1'b0, 32'h2000_0008, 32'h0);
    chk("t4b_lat",   64'(lat), 64'd16);
    chk("t4b_err",   64'(er),  64'd0);
    chk("t4b_rdata", 64'(rd),  64'h2222_2222);
    ack_wait[2] = 13;
    access(1'b0, 32'h2000_000C, 32'h0);
    chk("t4c_lat", 64'(lat), 64'd15);
    chk("t4c_err", 64'(er),  64'd0);

    // Async reset mid-wait.
    ack_wait[2] = -1;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h2000_0000;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_sel_pre", 64'(bus.slv_sel), 64'h4);
    rst = 1'b1;
    #1;
    chk("t5_sel",  64'(bus.slv_sel),  64'd0);
    chk("t5_done", 64'(bus.cpu_done), 64'd0);
    bus.cpu_req = 1'b0; bus.cpu_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b0, 32'h0000_0020, 32'h0);
    chk("t5_lat",   64'(lat), 64'd2);
    chk("t5_rdata", 64'(rd),  64'hCAFE_0000);
    chk("t5_err",   64'(er),  64'd0);

`ifdef BRIDGE_ERR_LOG_EN
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    access(1'b0, 32'h8000_0000, 32'h0);
    access(1'b0, 32'h8000_0100, 32'h0);
    chk("t6_cnt",  64'(err_cnt),  64'd2);
    chk("t6_addr", 64'(err_addr), 64'h8000_0100);
    clr_on_done = 1'b1;
    access(1'b0, 32'h8000_0200, 32'h0);
    clr_on_done = 1'b0;
    chk("t6_clr_cnt",  64'(err_cnt),  64'd0);
    chk("t6_clr_addr", 64'(err_addr), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
